// File: rtl/ifid_fetch_queue.sv
// ============================================================================
// Module   : ifid_fetch_queue
// Purpose  : Decoupling instruction queue between the fetch stage and the
//            decode stage. Buffers up to DEPTH {pc, instr} pairs with
//            valid/ready handshakes on both sides. A redirect (flush)
//            discards every buffered entry. When no valid entry is at the
//            head, decode sees PC 0 and the NOP instruction.
// Options  : IFQ_BYPASS_EN - when defined, an instruction arriving at an
//            empty queue that decode can take right away goes straight
//            through (0-cycle latency) without being stored.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ifid_fetch_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'hE6000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     flush,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] c_full_count = DEPTH[AW:0];

  // Storage is deliberately not reset; the outputs are masked whenever
  // the head is not valid, so stale contents never reach decode.
  logic [31:0]   r_mem_pc    [DEPTH];
  logic [31:0]   r_mem_instr [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_bypass;
  logic w_push;
  logic w_pop;
  logic w_head_valid;

  // Full/empty come from the entry count; pointers alone are ambiguous
  // when they are equal.
  always_comb begin
    w_full  = (r_count == c_full_count);
    w_empty = (r_count == '0);
  end

`ifdef IFQ_BYPASS_EN
  // Pass-through: empty queue, fetch has an instruction, decode can take it.
  // Reset is folded in so outputs return to idle the same cycle reset rises.
  always_comb begin
    w_bypass = w_empty & in_valid & out_ready & ~flush & ~reset;
  end
`else
  // No pass-through path: outputs depend on stored state only.
  always_comb begin
    w_bypass = 1'b0;
  end
`endif

  // Handshake qualification. Flush has priority over both sides; a bypassed
  // instruction is consumed directly and never written into storage.
  always_comb begin
    w_head_valid = ~w_empty & ~flush;
    w_push       = in_valid & ~w_full & ~flush & ~w_bypass;
    w_pop        = w_head_valid & out_ready;
  end

  // Fetch-side ready looks only at the registered count, so a full queue
  // refuses a push even in a cycle where decode pops.
  always_comb begin
    in_ready  = ~w_full;
    occupancy = r_count;
  end

  // Head presentation: bypass data, stored head, or idle PC 0 / NOP.
  always_comb begin
    out_valid = w_head_valid | w_bypass;
    out_pc    = 32'h0;
    out_instr = NOP_INSTR;
    if (w_bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (w_head_valid) begin
      out_pc    = r_mem_pc[r_rd_ptr];
      out_instr = r_mem_instr[r_rd_ptr];
    end
  end

  // Entry storage write on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_pc[r_wr_ptr]    <= in_pc;
      r_mem_instr[r_wr_ptr] <= in_instr;
    end
  end

  // Pointer and count update; flush empties the queue at the next edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire
